mem_responder: RTL and testbench

//   Unified word-organised instruction/data memory that services the MemRead/MemWrite

---
 rtl/mem_responder.sv | 171 +++++++++++++++++
 tb/tb_mem_responder.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// mem_responder: word-organised unified instruction/data memory for the
// multi-cycle CPU. It accepts a MemRead/MemWrite strobe in IDLE, spends
// WAIT_CYC wait states, then performs the access and pulses mem_ready for
// one cycle while in RESP.
// The optional macro MEM_BYTE_STROBE_EN adds the be port. With it, writes
// update only the enabled byte lanes. Without it, every write updates the
// full word.
module mem_responder #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_BYTE_STROBE_EN
  input  logic [3:0]        be,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              mem_ready,
  output logic              busy,
  output logic              addr_err
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t state, state_next;
  logic [3:0] cnt, cnt_next;

  logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

  // Request captured at the accept edge.
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic              wr_ok_q, rd_ok_q, err_q;

  // Decode of the live request inputs.
  logic              strobe, bad_addr, req_wr_ok, req_rd_ok, req_err;
  logic [ADDR_W-1:0] req_idx;
  logic [3:0]        req_be;

  // Access performed on the edge that enters RESP.
  logic              do_access, acc_wr, acc_rd;
  logic [ADDR_W-1:0] acc_idx;
  logic [DATA_W-1:0] acc_wdata;
  logic [3:0]        acc_be;

  // Classify the incoming request. Misaligned or out-of-range addresses
  // are errors. When both strobes are high, the access is treated as a write
  // and flagged as an error.
  always_comb begin
    strobe    = mem_read | mem_write;
    bad_addr  = (addr[1:0] != 2'b00) || ((addr >> (ADDR_W + 2)) != 32'd0);
    req_idx   = addr[ADDR_W+1:2];
    req_wr_ok = mem_write & ~bad_addr;
    req_rd_ok = mem_read & ~mem_write & ~bad_addr;
    req_err   = bad_addr | (mem_read & mem_write);
`ifdef MEM_BYTE_STROBE_EN
    req_be    = be;
`else
    req_be    = 4'hF;
`endif
  end

  // State register and wait-state counter.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic. This block also decides when the access happens and
  // which request it uses. With zero wait states, the access uses the live
  // inputs because nothing has been latched yet.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    do_access  = 1'b0;
    acc_wr     = wr_ok_q;
    acc_rd     = rd_ok_q;
    acc_idx    = idx_q;
    acc_wdata  = wdata_q;
    acc_be     = be_q;
    case (state)
      IDLE: begin
        if (strobe) begin
          if (WAIT_CYC == 0) begin
            state_next = RESP;
            do_access  = 1'b1;
            acc_wr     = req_wr_ok;
            acc_rd     = req_rd_ok;
            acc_idx    = req_idx;
            acc_wdata  = wdata;
            acc_be     = req_be;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYC);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_next = RESP;
          do_access  = 1'b1;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Latch the request at the accept edge. Later strobe changes are ignored.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idx_q   <= '0;
      wdata_q <= '0;
      be_q    <= 4'h0;
      wr_ok_q <= 1'b0;
      rd_ok_q <= 1'b0;
      err_q   <= 1'b0;
    end else if (state == IDLE && strobe) begin
      idx_q   <= req_idx;
      wdata_q <= wdata;
      be_q    <= req_be;
      wr_ok_q <= req_wr_ok;
      rd_ok_q <= req_rd_ok;
      err_q   <= req_err;
    end
  end

  // Read data register. It changes only on a successful read.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rdata <= '0;
    end else if (do_access && acc_rd) begin
      rdata <= mem[acc_idx];
    end
  end

  // Memory array write port. The array contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_access && acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) begin
          mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
        end
      end
    end
  end

  // Handshake outputs. The error flag is shown only alongside mem_ready.
  always_comb begin
    busy      = (state != IDLE);
    mem_ready = (state == RESP);
    addr_err  = (state == RESP) & err_q;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized and directed bench for mem_responder. The
// expected results come from a word-indexed model of the memory contents.
module tb_mem_responder;

  localparam int ADDR_W   = 8;
  localparam int WAIT_CYC = 2;
  localparam int LAT      = WAIT_CYC + 1;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
`ifdef MEM_BYTE_STROBE_EN
  logic [3:0]  be_v = 4'hF;
`endif
  logic [31:0] rdata;
  logic        mem_ready, busy, addr_err;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] model_mem [int];
  logic [31:0] last_rdata = 32'h0;

  mem_responder #(.ADDR_W(ADDR_W), .DATA_W(32), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk),
    .nrst(nrst),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .addr(addr),
    .wdata(wdata),
`ifdef MEM_BYTE_STROBE_EN
    .be(be_v),
`endif
    .rdata(rdata),
    .mem_ready(mem_ready),
    .busy(busy),
    .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lane_mask(input logic [3:0] b);
`ifdef MEM_BYTE_STROBE_EN
    return b;
`else
    return b | 4'hF;
`endif
  endfunction

  // Reference behaviour: error rules, then a write, a read, or neither.
  task automatic model_apply(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] b,
                             output logic [31:0] exp_rd, output logic exp_err);
    bit bad;
    int idx;
    logic [31:0] word;
    logic [3:0] m;
    bad = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    idx = int'(a[ADDR_W+1:2]);
    exp_err = bad || (rd && wr);
    if (!bad && wr) begin
      word = model_mem.exists(idx) ? model_mem[idx] : 32'h0;
      m = lane_mask(b);
      for (int i = 0; i < 4; i++) if (m[i]) word[8*i +: 8] = d[8*i +: 8];
      model_mem[idx] = word;
    end else if (!bad && rd) begin
      last_rdata = model_mem.exists(idx) ? model_mem[idx] : 32'hx;
    end
    exp_rd = last_rdata;
  endtask

  // Drive one request, hold it until mem_ready, then drop it in the next cycle.
  task automatic run_access(input logic rd, input logic wr, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] b,
                            output logic [31:0] rdv, output logic errv, output int lat,
                            output bit busy_ok, output bit pulse_ok);
    int n;
    @(negedge clk);
    mem_read = rd; mem_write = wr; addr = a; wdata = d;
`ifdef MEM_BYTE_STROBE_EN
    be_v = b;
`else
    if (b != 4'hF) $display("[TB] note: byte strobes ignored in this build");
`endif
    @(posedge clk);
    n = 0; lat = -1; busy_ok = 1; rdv = 32'h0; errv = 1'b0;
    while (n < 20 && lat < 0) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 0;
      if (mem_ready) begin
        lat = n; rdv = rdata; errv = addr_err;
      end
    end
    @(negedge clk);
    pulse_ok = !mem_ready && !busy;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (rdata !== 32'h0 || mem_ready !== 1'b0 || busy !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0",
               rdata, mem_ready, busy, addr_err);
    end
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po;
    run_access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, er, ee);
    n_checks++;
    if (lat !== LAT || !bo || !po) begin
      n_fail++;
      $display("[TB] FAIL write_latency: lat=%0d busy_ok=%0d pulse_ok=%0d, required %0d/1/1", lat, bo, po, LAT);
    end
    n_checks++;
    if (e !== ee) begin n_fail++; $display("[TB] FAIL write_err: got %b required %b", e, ee); end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (lat !== LAT || !bo || !po) begin
      n_fail++;
      $display("[TB] FAIL read_latency: lat=%0d busy_ok=%0d pulse_ok=%0d, required %0d/1/1", lat, bo, po, LAT);
    end
    n_checks++;
    if (r !== er) begin n_fail++; $display("[TB] FAIL read_data: got %h required %h", r, er); end
  endtask

  task automatic test_misaligned();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po;
    run_access(1'b0, 1'b1, 32'h12, 32'h11111111, 4'hF, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h12, 32'h11111111, 4'hF, er, ee);
    n_checks++;
    if (e !== ee || lat !== LAT) begin
      n_fail++; $display("[TB] FAIL misaligned_err: err=%b lat=%0d required %b/%0d", e, lat, ee, LAT);
    end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (r !== er || e !== ee) begin
      n_fail++; $display("[TB] FAIL misaligned_readback: data=%h err=%b required %h/%b", r, e, er, ee);
    end
  endtask

  task automatic test_both_strobes();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po;
    run_access(1'b1, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b1, 32'h14, 32'h5A5A5A5A, 4'hF, er, ee);
    n_checks++;
    if (e !== ee || r !== er) begin
      n_fail++; $display("[TB] FAIL both_err: err=%b data=%h required %b/%h", e, r, ee, er);
    end
    run_access(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h14, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (r !== er || e !== ee) begin
      n_fail++; $display("[TB] FAIL both_readback: data=%h err=%b required %h/%b", r, e, er, ee);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po;
    run_access(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h0000_0400, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (r !== er || e !== ee || lat !== LAT) begin
      n_fail++; $display("[TB] FAIL range_read: data=%h err=%b lat=%0d required %h/%b/%0d", r, e, lat, er, ee, LAT);
    end
    run_access(1'b0, 1'b1, 32'h8000_0010, 32'h99999999, 4'hF, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h8000_0010, 32'h99999999, 4'hF, er, ee);
    n_checks++;
    if (e !== ee) begin n_fail++; $display("[TB] FAIL range_write_err: got %b required %b", e, ee); end
  endtask

  task automatic test_reset_idle();
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    last_rdata = 32'h0;
    n_checks++;
    if (rdata !== 32'h0 || mem_ready !== 1'b0 || busy !== 1'b0 || addr_err !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: rdata=%h ready=%b busy=%b err=%b, required 0/0/0/0",
               rdata, mem_ready, busy, addr_err);
    end
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic test_reset_wait();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po; int seen;
    run_access(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h20, 32'hCAFEF00D, 4'hF, er, ee);
    @(negedge clk);
    mem_write = 1'b1; addr = 32'h20; wdata = 32'h00001234;
    @(posedge clk);
    @(negedge clk);
    seen = mem_ready ? 1 : 0;
    nrst = 1'b0;
    mem_write = 1'b0;
    #1;
    last_rdata = 32'h0;
    n_checks++;
    if (busy !== 1'b0 || mem_ready !== 1'b0 || rdata !== 32'h0) begin
      n_fail++; $display("[TB] FAIL reset_wait_abort: busy=%b ready=%b rdata=%h required 0/0/0", busy, mem_ready, rdata);
    end
    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_ready) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("[TB] FAIL reset_wait_ready: saw %0d pulses required 0", seen); end
    run_access(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h20, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (r !== er) begin n_fail++; $display("[TB] FAIL reset_wait_readback: got %h required %h", r, er); end
  endtask

  task automatic test_back_to_back();
    int pulses, p1, p2;
    logic [31:0] r1, r2, er; logic ee;
    pulses = 0; p1 = -1; p2 = -1; r1 = 32'h0; r2 = 32'h0;
    @(negedge clk);
    mem_read = 1'b1; addr = 32'h10;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_ready) begin
        pulses++;
        if (pulses == 1) begin p1 = n; r1 = rdata; end
        else begin p2 = n; r2 = rdata; end
      end
      if (n == 2 * LAT + 2) mem_read = 1'b0;
    end
    model_apply(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (pulses != 2 || p1 != LAT || p2 != 2 * LAT + 1) begin
      n_fail++; $display("[TB] FAIL b2b_timing: pulses=%0d at %0d,%0d required 2 at %0d,%0d", pulses, p1, p2, LAT, 2 * LAT + 1);
    end
    n_checks++;
    if (r1 !== er || r2 !== er) begin
      n_fail++; $display("[TB] FAIL b2b_data: got %h,%h required %h", r1, r2, er);
    end
  endtask

`ifdef MEM_BYTE_STROBE_EN
  task automatic test_byte_strobe();
    logic [31:0] r, er; logic e, ee; int lat; bit bo, po;
    run_access(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h10, 32'hAABBCCDD, 4'b0011, er, ee);
    run_access(1'b0, 1'b1, 32'h10, 32'h77777777, 4'b0000, r, e, lat, bo, po);
    model_apply(1'b0, 1'b1, 32'h10, 32'h77777777, 4'b0000, er, ee);
    n_checks++;
    if (lat !== LAT || e !== ee) begin
      n_fail++; $display("[TB] FAIL be_zero_handshake: lat=%0d err=%b required %0d/%b", lat, e, LAT, ee);
    end
    run_access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, r, e, lat, bo, po);
    model_apply(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, er, ee);
    n_checks++;
    if (r !== er || er !== 32'hDEADCCDD) begin
      n_fail++; $display("[TB] FAIL be_merge: got %h required %h", r, er);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] r, er, a, d; logic e, ee, rd, wr; int lat; bit bo, po; int idx, kind;
    logic [3:0] b;
    for (int k = 0; k < 40; k++) begin
      idx = int'($urandom_range(16, 23));
      a = 32'(idx) << 2;
      d = $urandom;
      b = 4'($urandom);
      kind = int'($urandom_range(0, 9));
      rd = 1'b0; wr = 1'b0;
      if (!model_mem.exists(idx)) begin wr = 1'b1; b = 4'hF; end
      else if (kind < 4) rd = 1'b1;
      else if (kind < 7) wr = 1'b1;
      else if (kind == 7) begin rd = 1'b1; wr = 1'b1; end
      else if (kind == 8) begin rd = 1'b1; a = a | 32'($urandom_range(1, 3)); end
      else begin wr = 1'b1; a = a | (32'h1 << $urandom_range(10, 31)); end
      run_access(rd, wr, a, d, b, r, e, lat, bo, po);
      model_apply(rd, wr, a, d, b, er, ee);
      n_checks++;
      if (r !== er || e !== ee || lat !== LAT || !bo || !po) begin
        n_fail++;
        $display("[TB] FAIL random_%0d: rd=%b wr=%b a=%h data=%h err=%b lat=%0d bo=%0d po=%0d required data=%h err=%b lat=%0d",
                 k, rd, wr, a, r, e, lat, bo, po, er, ee, LAT);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_both_strobes();
    test_out_of_range();
    test_reset_idle();
    test_reset_wait();
    test_back_to_back();
`ifdef MEM_BYTE_STROBE_EN
    test_byte_strobe();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
